conv_window_feeder: RTL
=======================

// Module: conv_window_feeder
// PURPOSE
//  Source side of the 4x4 convolution datapath. Accepts a raster-order pixel stream.
//  Buffers the previous 3 image rows and emits every stride-1 4x4 window.
//  Output taps are data(r,c), in the same order as the conv core's data00..data33 inputs.
//  Sits between the pixel source and the conv core; kernel taps are supplied elsewhere.
// PARAMETERS
//  LEN_IN  8   bits per pixel (signed, passed through unmodified)
//  IMG_W   32  pixels per row; legal range 4..1024
//  IMG_H   32  rows per frame; legal range 4..1024
// PORTS
//  clk         in   1          single clock, rising edge
//  rst_n       in   1          synchronous reset, active-low
//  in_valid    in   1          pixel present on in_pixel
//  in_ready    out  1          feeder can accept a pixel this cycle
//  in_pixel    in   LEN_IN     signed pixel, raster order (row-major, top-left first)
//  win_valid   out  1          win_data holds a complete window
//  win_ready   in   1          downstream consumes the window this cycle
//  win_data    out  16*LEN_IN  tap (r,c) at [(r*4+c)*LEN_IN +: LEN_IN]; r,c in 0..3
//  frame_done  out  1          1-cycle pulse after the last pixel of a frame is accepted
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    - row/col counters=0, win_valid=0, frame_done=0, window regs=0.
//    - Line-buffer RAM contents are not cleared; stale data is never emitted (see validity).
//  - Handshakes:
//    - Pixel accepted when in_valid&&in_ready.
//    - in_ready = !win_valid || win_ready (combinational).
//    - Window transferred when win_valid&&win_ready.
//  - On each accepted pixel at (row,col):
//    - Column vector = {lb2[col], lb1[col], lb0[col], in_pixel}, i.e. rows row-3..row.
//    - Line buffers shift: lb2[col]<=lb1[col], lb1[col]<=lb0[col], lb0[col]<=in_pixel.
//    - Window regs shift left one column; the new vector enters column 3.
//    - Result: tap(3,3) = current pixel, tap(0,0) = pixel(row-3,col-3).
//    - col increments; at IMG_W-1 col wraps to 0 and row increments.
//    - At (IMG_H-1, IMG_W-1) both wrap to 0 and frame_done pulses the next cycle.
//  - Window validity and latency:
//    - win_valid<=1 on the cycle after an accept with row>=3 && col>=3; latency 1 cycle.
//    - Windows per frame = (IMG_W-3)*(IMG_H-3); none straddle a row boundary.
//  - Stall:
//    - While win_valid && !win_ready, in_ready=0.
//    - win_data, win_valid, counters and line buffers hold.
//  - Drain:
//    - win_ready=1 with no accept the same cycle -> win_valid<=0.
//  - Simultaneous events:
//    - win_ready=1 with an accept the same cycle -> win_valid takes the new window's validity (back-to-back, no bubble).
//  - Frame wrap: next frame starts at (0,0) with no idle cycle required.
//    - Old-frame rows in the line buffers are fully overwritten before row 3 of the new frame, so no cross-frame window is emitted.
//  - Reset mid-frame: restart at (0,0) the cycle after rst_n returns high.
//    - A pending window is dropped; no frame_done is issued for the aborted frame.
//  - Width rules: no arithmetic on pixels; counters are $clog2(IMG_W) and $clog2(IMG_H) bits.
// STRUCTURE
//  - Package conv_pkg:
//    - LEN_IN default, K=4, WIN_TAPS=16.
//    - Function tap_lsb(r,c) = (r*K+c)*LEN_IN, shared with the conv core wrapper.
//  - Sub-module conv_line_buffer: IMG_W x (3*LEN_IN) RAM.
//    - Read and write at the same address in one cycle (read-before-write).
//    - Instantiated once; the 3 rows are packed per word.
//  - The top level holds the counters, the 4x4 window shift register and the handshake logic.
// TESTING  (IMG_W=8, IMG_H=6, pixel(r,c)=16*r+c, so the hex value reads "rc")
//  1. Stream the frame, in_valid=1, win_ready=1 always:
//     - 15 windows, back-to-back within each row.
//     - First window tap(0,0)=0x00, tap(3,3)=0x33. Last window tap(0,0)=0x24, tap(3,3)=0x57.
//     - frame_done pulses exactly once, 1 cycle after pixel 0x57 is accepted.
//  2. Hold win_ready=0 for 5 cycles on the first window:
//     - in_ready=0 and win_data stable at 0x00..0x33 throughout.
//     - After release the next window has tap(3,3)=0x34; no window is lost or duplicated.
//  3. Drive in_valid randomly at 50% with win_ready=1:
//     - The window sequence is identical to test 1 (15 windows, same taps).
//  4. Send two frames back-to-back, frame 2 with pixel+0x40:
//     - Frame 2's first window has tap(0,0)=0x40, tap(3,3)=0x73.
//     - No window mixes frame-1 and frame-2 rows.
//  5. Assert rst_n=0 for 1 cycle after pixel 0x42, then resend a full frame:
//     - win_valid=0 and frame_done=0 during reset.
//     - Output matches test 1 exactly.
//  6. Toggle win_ready every cycle:
//     - Every window is transferred exactly once.
//     - in_ready never goes high while win_valid && !win_ready.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the 4x4 convolution datapath: window geometry and tap
// placement inside the packed window bus.
package conv_pkg;
  localparam int LEN_IN_DEF = 8;
  localparam int K          = 4;
  localparam int WIN_TAPS   = K * K;

  // LSB of tap (r,c) inside a packed window of len-bit taps.
  function automatic int tap_lsb(input int r, input int c, input int len = LEN_IN_DEF);
    return (r * K + c) * len;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// Single-port line buffer holding the three previous rows packed per word.
// Read is combinational, so a same-cycle write at the same address returns the old word.
module conv_line_buffer #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/conv_window_feeder.sv
// Turns a raster pixel stream into every stride-1 4x4 window of the frame.
// Handshake: a pixel moves on in_valid&&in_ready, a window moves on win_valid&&win_ready.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int LEN_IN = LEN_IN_DEF,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LEN_IN-1:0]          in_pixel,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [WIN_TAPS*LEN_IN-1:0] win_data,
  output logic                       frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic                         win_valid_q, win_valid_d;
  logic                         frame_done_q, frame_done_d;
  logic [WIN_TAPS*LEN_IN-1:0]   win_q, win_d;
  logic                         accept;
  logic [3*LEN_IN-1:0]          lb_rd, lb_wr;
  logic [LEN_IN-1:0]            col_vec [K];

  assign in_ready   = !win_valid_q || win_ready;
  assign accept     = in_valid && in_ready;
  assign win_valid  = win_valid_q;
  assign win_data   = win_q;
  assign frame_done = frame_done_q;

  // Word layout is {row-3, row-2, row-1}; writing {row-2, row-1, pixel} ages every row by one.
  always_comb begin
    col_vec[0] = lb_rd[2*LEN_IN +: LEN_IN];
    col_vec[1] = lb_rd[LEN_IN +: LEN_IN];
    col_vec[2] = lb_rd[0 +: LEN_IN];
    col_vec[3] = in_pixel;
  end
  assign lb_wr = {col_vec[1], col_vec[2], in_pixel};

  conv_line_buffer #(
    .WIDTH (3 * LEN_IN),
    .DEPTH (IMG_W)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb_wr),
    .rdata_o (lb_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    win_d        = win_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
      // Any earlier column would mix the tail of the previous row into the window.
      win_valid_d  = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          if (c < K - 1) win_d[tap_lsb(r, c, LEN_IN) +: LEN_IN] = win_q[tap_lsb(r, c + 1, LEN_IN) +: LEN_IN];
          else           win_d[tap_lsb(r, c, LEN_IN) +: LEN_IN] = col_vec[r];
        end
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end
endmodule
